// File: rtl/axis_tlast_check_if.sv
// AXI-Stream bundle used on both sides of axis_tlast_check.
//   tvalid / tready : handshake
//   tdata           : payload, TDATA_WIDTH bits
//   tlast           : end of packet
// master modport drives tvalid/tdata/tlast, slave modport drives tready.
interface axis_tlast_check_if #(
  parameter int TDATA_WIDTH = 8
) ();
  logic                   tvalid;
  logic                   tready;
  logic [TDATA_WIDTH-1:0] tdata;
  logic                   tlast;

  modport master (output tvalid, output tdata, output tlast, input tready);
  modport slave  (input tvalid, input tdata, input tlast, output tready);
endinterface

// File: rtl/axis_tlast_check.sv
// axis_tlast_check
// Receive-side packet length checker. Counts beats per packet against
// PKT_LENGTH, forwards the stream through a 2-entry skid buffer, truncates
// over-long packets with a forced tlast and keeps saturating statistics.
//
// Ports
//   aclk, resetn        clock, synchronous active-low reset
//   s_axis (slave)      input stream  (tvalid/tready/tdata/tlast)
//   m_axis (master)     output stream, registered, tlast regenerated
//   good_count          packets of exactly PKT_LENGTH beats
//   short_count         packets ending before PKT_LENGTH beats
//   long_count          packets still open at beat PKT_LENGTH (truncated)
//   in_packet           high while the FSM is not IDLE
//
// Optional build macro AXIS_TLAST_CHECK_IRQ_EN adds:
//   err_irq     one-cycle pulse when a short/long error is counted
//   err_sticky  {long, short} sticky error flags
//   err_clear   clears err_sticky (a same-cycle new error wins)
module axis_tlast_check #(
  parameter int TDATA_WIDTH = 8,
  parameter int PKT_LENGTH  = 1024 * 1024,
  parameter int CNT_WIDTH   = 32
) (
  input  logic                 aclk,
  input  logic                 resetn,
  axis_tlast_check_if.slave    s_axis,
  axis_tlast_check_if.master   m_axis,
  output logic [CNT_WIDTH-1:0] good_count,
  output logic [CNT_WIDTH-1:0] short_count,
  output logic [CNT_WIDTH-1:0] long_count,
  output logic                 in_packet
`ifdef AXIS_TLAST_CHECK_IRQ_EN
  ,
  output logic                 err_irq,
  output logic [1:0]           err_sticky,
  input  logic                 err_clear
`endif
);

  localparam int BCNT_W = $clog2(PKT_LENGTH + 1);
  localparam logic [BCNT_W-1:0] LAST_IDX = BCNT_W'(PKT_LENGTH - 1);

  typedef enum logic [1:0] {IDLE = 2'd0, PASS = 2'd1, DROP = 2'd2} state_t;

  state_t                 state_q, state_d;
  logic [BCNT_W-1:0]      bcnt_q, bcnt_d;
  logic                   tready_q, tready_d;
  logic                   accept;
  logic                   good_ev, short_ev, long_ev;
  logic                   fwd_we, fwd_last;

  // skid buffer: out_* is the visible output register, skid_* the overflow slot
  logic                   out_valid_q, out_valid_d;
  logic [TDATA_WIDTH-1:0] out_data_q, out_data_d;
  logic                   out_last_q, out_last_d;
  logic                   skid_valid_q, skid_valid_d;
  logic [TDATA_WIDTH-1:0] skid_data_q, skid_data_d;
  logic                   skid_last_q, skid_last_d;

  assign accept = s_axis.tvalid && tready_q;

  // ---------------- FSM: state register ----------------
  always_ff @(posedge aclk) begin
    if (!resetn) begin
      state_q <= IDLE;
      bcnt_q  <= '0;
    end else begin
      state_q <= state_d;
      bcnt_q  <= bcnt_d;
    end
  end

  // ---------------- FSM: next state ----------------
  // IDLE and PASS share the same beat handling; bcnt is 0 in IDLE, so a
  // PKT_LENGTH of 1 makes the very first beat the last one.
  always_comb begin
    state_d  = state_q;
    bcnt_d   = bcnt_q;
    good_ev  = 1'b0;
    short_ev = 1'b0;
    long_ev  = 1'b0;
    if (accept) begin
      case (state_q)
        IDLE, PASS: begin
          if (bcnt_q == LAST_IDX) begin
            if (s_axis.tlast) begin
              good_ev = 1'b1;
              state_d = IDLE;
              bcnt_d  = '0;
            end else begin
              long_ev = 1'b1;
              state_d = DROP;
              bcnt_d  = bcnt_q + BCNT_W'(1);
            end
          end else if (s_axis.tlast) begin
            // includes a 1-beat packet seen straight from IDLE
            short_ev = 1'b1;
            state_d  = IDLE;
            bcnt_d   = '0;
          end else begin
            state_d = PASS;
            bcnt_d  = bcnt_q + BCNT_W'(1);
          end
        end
        DROP: begin
          if (s_axis.tlast) begin
            state_d = IDLE;
            bcnt_d  = '0;
          end
        end
        default: begin
          state_d = IDLE;
          bcnt_d  = '0;
        end
      endcase
    end
  end

  // ---------------- FSM: outputs ----------------
  always_comb begin
    in_packet = (state_q != IDLE);
    fwd_we    = accept && (state_q != DROP);
    fwd_last  = s_axis.tlast || long_ev;   // forced tlast on truncation
  end

  // ---------------- skid buffer ----------------
  always_comb begin
    out_valid_d  = out_valid_q;
    out_data_d   = out_data_q;
    out_last_d   = out_last_q;
    skid_valid_d = skid_valid_q;
    skid_data_d  = skid_data_q;
    skid_last_d  = skid_last_q;
    if (!out_valid_q || m_axis.tready) begin
      if (skid_valid_q) begin
        out_valid_d  = 1'b1;
        out_data_d   = skid_data_q;
        out_last_d   = skid_last_q;
        skid_valid_d = fwd_we;
        if (fwd_we) begin
          skid_data_d = s_axis.tdata;
          skid_last_d = fwd_last;
        end
      end else if (fwd_we) begin
        out_valid_d = 1'b1;
        out_data_d  = s_axis.tdata;
        out_last_d  = fwd_last;
      end else begin
        out_valid_d = 1'b0;
      end
    end else if (fwd_we) begin
      skid_valid_d = 1'b1;
      skid_data_d  = s_axis.tdata;
      skid_last_d  = fwd_last;
    end
    // DROP swallows beats, so it never needs buffer space
    tready_d = (state_d == DROP) || !skid_valid_d;
  end

  always_ff @(posedge aclk) begin
    if (!resetn) begin
      out_valid_q  <= 1'b0;
      out_data_q   <= '0;
      out_last_q   <= 1'b0;
      skid_valid_q <= 1'b0;
      skid_data_q  <= '0;
      skid_last_q  <= 1'b0;
      tready_q     <= 1'b0;
    end else begin
      out_valid_q  <= out_valid_d;
      out_data_q   <= out_data_d;
      out_last_q   <= out_last_d;
      skid_valid_q <= skid_valid_d;
      skid_data_q  <= skid_data_d;
      skid_last_q  <= skid_last_d;
      tready_q     <= tready_d;
    end
  end

  assign s_axis.tready = tready_q;
  assign m_axis.tvalid = out_valid_q;
  assign m_axis.tdata  = out_data_q;
  assign m_axis.tlast  = out_last_q;

  // ---------------- saturating statistics counters ----------------
  logic [2:0] cnt_ev;
  assign cnt_ev = {long_ev, short_ev, good_ev};

  generate
    for (genvar gi = 0; gi < 3; gi++) begin : g_cnt
      logic [CNT_WIDTH-1:0] cnt_q;
      always_ff @(posedge aclk) begin
        if (!resetn) begin
          cnt_q <= '0;
        end else if (cnt_ev[gi] && (cnt_q != {CNT_WIDTH{1'b1}})) begin
          cnt_q <= cnt_q + CNT_WIDTH'(1);
        end
      end
    end
  endgenerate

  assign good_count  = g_cnt[0].cnt_q;
  assign short_count = g_cnt[1].cnt_q;
  assign long_count  = g_cnt[2].cnt_q;

`ifdef AXIS_TLAST_CHECK_IRQ_EN
  logic       err_irq_q;
  logic [1:0] err_sticky_q, err_sticky_d;

  always_comb begin
    err_sticky_d = (err_clear ? 2'b00 : err_sticky_q) | {long_ev, short_ev};
  end

  always_ff @(posedge aclk) begin
    if (!resetn) begin
      err_irq_q    <= 1'b0;
      err_sticky_q <= 2'b00;
    end else begin
      err_irq_q    <= short_ev || long_ev;
      err_sticky_q <= err_sticky_d;
    end
  end

  assign err_irq    = err_irq_q;
  assign err_sticky = err_sticky_q;
`endif

endmodule

// File: tb/tb_axis_tlast_check.sv
module tb_axis_tlast_check;

  localparam int PKT = 8;

  logic aclk = 1'b0;
  logic resetn = 1'b0;
  logic [31:0] good_count, short_count, long_count;
  logic in_packet;
`ifdef AXIS_TLAST_CHECK_IRQ_EN
  logic err_irq;
  logic [1:0] err_sticky;
  logic err_clear = 1'b0;
  int irq_cnt = 0;
`endif

  axis_tlast_check_if #(.TDATA_WIDTH(8)) s_if ();
  axis_tlast_check_if #(.TDATA_WIDTH(8)) m_if ();

  axis_tlast_check #(
    .TDATA_WIDTH(8),
    .PKT_LENGTH (PKT),
    .CNT_WIDTH  (32)
  ) dut (
    .aclk       (aclk),
    .resetn     (resetn),
    .s_axis     (s_if),
    .m_axis     (m_if),
    .good_count (good_count),
    .short_count(short_count),
    .long_count (long_count),
    .in_packet  (in_packet)
`ifdef AXIS_TLAST_CHECK_IRQ_EN
    ,
    .err_irq    (err_irq),
    .err_sticky (err_sticky),
    .err_clear  (err_clear)
`endif
  );

  always #5 aclk = ~aclk;

  int checks = 0;
  int errors = 0;
  int cyc = 0;
  int stall_cycles = 0;
  int stab_err = 0;
  bit rnd_ready = 1'b0;
  bit prev_stall = 1'b0;
  logic [7:0] prev_data;
  logic prev_last;
  logic [7:0] exp_d[$];
  logic       exp_l[$];
  logic [7:0] obs_d[$];
  logic       obs_l[$];

  initial begin
    s_if.tvalid = 1'b0;
    s_if.tdata  = 8'h00;
    s_if.tlast  = 1'b0;
    m_if.tready = 1'b1;
  end

  always @(posedge aclk) begin
    cyc++;
    #1;
    m_if.tready = rnd_ready ? 1'($urandom_range(0, 1)) : 1'b1;
  end

  // output monitor: outputs are registered and tready changes only just
  // after posedge, so the negedge view equals what the next edge sees
  always @(negedge aclk) begin
    if (resetn) begin
      if (prev_stall && (!m_if.tvalid || m_if.tdata !== prev_data || m_if.tlast !== prev_last))
        stab_err++;
      if (m_if.tvalid && m_if.tready) begin
        obs_d.push_back(m_if.tdata);
        obs_l.push_back(m_if.tlast);
      end
      prev_stall = m_if.tvalid && !m_if.tready;
      prev_data  = m_if.tdata;
      prev_last  = m_if.tlast;
`ifdef AXIS_TLAST_CHECK_IRQ_EN
      if (err_irq) irq_cnt++;
`endif
    end else begin
      prev_stall = 1'b0;
    end
  end

  // Present one beat and return #1 after the edge that accepts it.
  task automatic send_beat(input logic [7:0] d, input logic l);
    int n;
    bit ok;
    s_if.tvalid = 1'b1;
    s_if.tdata  = d;
    s_if.tlast  = l;
    n = 0;
    forever begin
      ok = s_if.tready;
      @(posedge aclk);
      #1;
      if (ok) break;
      stall_cycles++;
      n++;
      if (n > 500) begin
        errors++;
        checks++;
        $display("FAIL send_timeout: tready stuck low, got %0d stall cycles, required < 500", n);
        break;
      end
    end
  endtask

  // Send an n-beat packet with data base+i; model the expected output.
  task automatic send_pkt(input int n, input int base);
    logic l;
    for (int i = 0; i < n; i++) begin
      l = (i == n - 1);
      send_beat(8'(base + i), l);
      if (i < PKT) begin
        exp_d.push_back(8'(base + i));
        exp_l.push_back(l || (i == PKT - 1));
      end
    end
  endtask

  task automatic drain_compare(input string name, input int budget);
    int n;
    s_if.tvalid = 1'b0;
    s_if.tlast  = 1'b0;
    n = 0;
    while (obs_d.size() < exp_d.size() && n < budget) begin
      @(posedge aclk);
      #1;
      n++;
    end
    repeat (4) @(posedge aclk);
    #1;
    checks++;
    if (obs_d.size() !== exp_d.size()) begin
      errors++;
      $display("FAIL %s_count: got %0d output beats, required %0d", name, obs_d.size(), exp_d.size());
    end
    for (int i = 0; i < exp_d.size() && i < obs_d.size(); i++) begin
      checks++;
      if (obs_d[i] !== exp_d[i] || obs_l[i] !== exp_l[i]) begin
        errors++;
        $display("FAIL %s_beat%0d: got data=%h last=%b, required data=%h last=%b",
                 name, i, obs_d[i], obs_l[i], exp_d[i], exp_l[i]);
      end
    end
    $display("%s: %0d beats compared", name, exp_d.size());
    exp_d.delete(); exp_l.delete(); obs_d.delete(); obs_l.delete();
  endtask

  task automatic check_counts(input string name, input int g, input int s, input int lg);
    checks++;
    if (good_count !== 32'(g) || short_count !== 32'(s) || long_count !== 32'(lg)) begin
      errors++;
      $display("FAIL %s_counters: got good=%0d short=%0d long=%0d, required good=%0d short=%0d long=%0d",
               name, good_count, short_count, long_count, g, s, lg);
    end
  endtask

  task automatic test_reset();
    resetn = 1'b0;
    repeat (3) @(posedge aclk);
    #1;
    checks++;
    if (s_if.tready !== 1'b0 || m_if.tvalid !== 1'b0 || m_if.tlast !== 1'b0 ||
        m_if.tdata !== 8'h00 || in_packet !== 1'b0) begin
      errors++;
      $display("FAIL reset_outputs: got tready=%b tvalid=%b tlast=%b tdata=%h in_packet=%b, required all 0",
               s_if.tready, m_if.tvalid, m_if.tlast, m_if.tdata, in_packet);
    end
    check_counts("reset", 0, 0, 0);
    resetn = 1'b1;
    @(posedge aclk);
    #1;
    $display("test_reset: done");
  endtask

  task automatic test_good();
    int c0;
    stall_cycles = 0;
    c0 = cyc;
    send_beat(8'h00, 1'b0);
    exp_d.push_back(8'h00);
    exp_l.push_back(1'b0);
    checks++;
    if (m_if.tvalid !== 1'b1 || m_if.tdata !== 8'h00) begin
      errors++;
      $display("FAIL good_latency: got tvalid=%b tdata=%h one cycle after accept, required 1/00",
               m_if.tvalid, m_if.tdata);
    end
    for (int i = 1; i < PKT; i++) begin
      send_beat(8'(i), (i == PKT - 1));
      exp_d.push_back(8'(i));
      exp_l.push_back(i == PKT - 1);
    end
    for (int p = 1; p < 4; p++) send_pkt(PKT, p * PKT);
    checks++;
    if (cyc - c0 !== 4 * PKT || stall_cycles !== 0) begin
      errors++;
      $display("FAIL good_throughput: got %0d cycles %0d stalls for 32 beats, required 32/0",
               cyc - c0, stall_cycles);
    end
    drain_compare("test_good", 200);
    check_counts("good", 4, 0, 0);
  endtask

  task automatic test_short();
    send_pkt(5, 8'h60);
    send_pkt(PKT, 8'h70);
    drain_compare("test_short", 200);
    check_counts("short", 5, 1, 0);
  endtask

  task automatic test_long();
    for (int i = 0; i < PKT; i++) begin
      send_beat(8'(8'h80 + i), 1'b0);
      exp_d.push_back(8'(8'h80 + i));
      exp_l.push_back(i == PKT - 1);
    end
    checks++;
    if (in_packet !== 1'b1) begin
      errors++;
      $display("FAIL long_in_drop: got in_packet=%b after truncation, required 1", in_packet);
    end
    stall_cycles = 0;
    for (int i = PKT; i < 12; i++) send_beat(8'(8'h80 + i), (i == 11));
    checks++;
    if (stall_cycles !== 0 || in_packet !== 1'b0) begin
      errors++;
      $display("FAIL long_drop_ready: got %0d stalls in_packet=%b, required 0/0", stall_cycles, in_packet);
    end
    send_pkt(PKT, 8'h90);
    drain_compare("test_long", 200);
    check_counts("long", 6, 1, 1);
  endtask

  task automatic test_reset_mid();
    for (int i = 0; i < 3; i++) send_beat(8'(8'h40 + i), 1'b0);
    s_if.tvalid = 1'b1;
    s_if.tdata  = 8'h43;
    s_if.tlast  = 1'b0;
    resetn = 1'b0;
    @(posedge aclk);
    #1;
    checks++;
    if (m_if.tvalid !== 1'b0 || s_if.tready !== 1'b0 || in_packet !== 1'b0 || m_if.tdata !== 8'h00) begin
      errors++;
      $display("FAIL reset_mid_outputs: got tvalid=%b tready=%b in_packet=%b tdata=%h, required 0/0/0/00",
               m_if.tvalid, s_if.tready, in_packet, m_if.tdata);
    end
    check_counts("reset_mid_zero", 0, 0, 0);
    resetn = 1'b1;
    s_if.tvalid = 1'b0;
    exp_d.delete(); exp_l.delete(); obs_d.delete(); obs_l.delete();
    @(posedge aclk);
    #1;
    send_pkt(PKT, 8'hA0);
    drain_compare("test_reset_mid", 200);
    check_counts("reset_mid", 1, 0, 0);
  endtask

  task automatic test_random_ready();
    rnd_ready = 1'b1;
    stab_err = 0;
    for (int p = 0; p < 100; p++) send_pkt(PKT, p * PKT);
    drain_compare("test_random_ready", 5000);
    rnd_ready = 1'b0;
    checks++;
    if (stab_err !== 0) begin
      errors++;
      $display("FAIL random_stability: got %0d unstable stalled cycles, required 0", stab_err);
    end
    check_counts("random_ready", 101, 0, 0);
  endtask

`ifdef AXIS_TLAST_CHECK_IRQ_EN
  task automatic test_irq();
    irq_cnt = 0;
    send_pkt(3, 8'hC0);
    drain_compare("test_irq", 200);
    checks++;
    if (irq_cnt !== 1 || err_sticky !== 2'b01) begin
      errors++;
      $display("FAIL irq_pulse: got %0d pulses sticky=%b, required 1/01", irq_cnt, err_sticky);
    end
    err_clear = 1'b1;
    @(posedge aclk);
    #1;
    err_clear = 1'b0;
    checks++;
    if (err_sticky !== 2'b00) begin
      errors++;
      $display("FAIL irq_clear: got sticky=%b, required 00", err_sticky);
    end
  endtask
`endif

  initial begin
    test_reset();
    test_good();
    test_short();
    test_long();
    test_reset_mid();
    test_random_ready();
`ifdef AXIS_TLAST_CHECK_IRQ_EN
    test_irq();
`endif
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL global_timeout: simulation did not finish, required completion");
    $fatal(1, "timeout");
  end

endmodule
